// File: rtl/st_receiver_if.sv
// Handshake and data bundle between the serial transmitter/host side and
// st_receiver. The master modport is the transmitter/host view and the slave
// modport is the receiver view.
interface st_receiver_if;
    logic       rts;
    logic       rx;
    logic       rd;
    logic       ack;
    logic [0:7] q;
    logic       dv;
    logic       pe;
    logic       fe;
    logic       ovr;

    modport master (output rts, rx, rd, input ack, q, dv, pe, fe, ovr);
    modport slave  (input rts, rx, rd, output ack, q, dv, pe, fe, ovr);
endinterface

// File: rtl/st_receiver.sv
// st_receiver: acknowledges an RTS request, then deserialises one frame
// (start 0, 8 data bits first-bit-into-q[0], odd parity, stop 1) into a
// one-entry host buffer with parity, framing and overrun status.
// Optional: define STRX_SYNC_EN to pass rx and rts through 2-flop synchronizers
// first, which adds 2 cycles to every rx/rts-relative latency.
//
// state      | meaning
// IDLE       | waiting for rts
// WAIT_START | ack high, waiting for rx low (bounded by START_TIMEOUT)
// START      | timing to the middle of the start bit
// DATA       | sampling the 8 data bits, one per bit period
// PARITY     | sampling the parity bit
// STOP       | sampling the stop bit, then committing to the buffer
// HOLD       | frame done or timed out, waiting for rts to drop
module st_receiver #(
    parameter int CLKS_PER_BIT  = 16,
    parameter int START_TIMEOUT = 1024
) (
    input logic         clk,
    input logic         rst,
    st_receiver_if.slave bus
);
    localparam int TW  = $clog2(CLKS_PER_BIT) + 1;
    localparam int TOW = $clog2(START_TIMEOUT) + 1;
    localparam logic [TW-1:0]  HALF_LOAD = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0]  BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]  TMR_ONE   = TW'(1);
    localparam logic [TOW-1:0] TOUT_LOAD = TOW'(START_TIMEOUT - 1);
    localparam logic [TOW-1:0] TOUT_ONE  = TOW'(1);

    typedef enum logic [2:0] {IDLE, WAIT_START, START, DATA, PARITY, STOP, HOLD} state_t;

    state_t         state, state_nxt;
    logic           rx_s, rts_s;
    logic [TW-1:0]  tmr;
    logic [TOW-1:0] tout;
    logic [3:0]     bidx;
    logic [0:7]     sh;
    logic           par;
    logic           tmr_tc, commit, ack_nxt;
    logic           ack_r, dv_r, pe_r, fe_r, ovr_r;
    logic [0:7]     q_r;

`ifdef STRX_SYNC_EN
    logic [1:0] rx_ff, rts_ff;

    // Two-flop synchronizers; rx resets to its idle level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_ff  <= 2'b11;
            rts_ff <= 2'b00;
        end else begin
            rx_ff  <= {rx_ff[0], bus.rx};
            rts_ff <= {rts_ff[0], bus.rts};
        end
    end
    assign rx_s  = rx_ff[1];
    assign rts_s = rts_ff[1];
`else
    assign rx_s  = bus.rx;
    assign rts_s = bus.rts;
`endif

    assign tmr_tc = (tmr == '0);
    assign commit = (state == STOP) && tmr_tc;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode; ack follows the next state so it is registered.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (rts_s) state_nxt = WAIT_START;
            WAIT_START: begin
                if (!rx_s)              state_nxt = START;
                else if (tout == '0)    state_nxt = HOLD;
            end
            START:      if (tmr_tc) state_nxt = rx_s ? WAIT_START : DATA;
            DATA:       if (tmr_tc && bidx == 4'd7) state_nxt = PARITY;
            PARITY:     if (tmr_tc) state_nxt = STOP;
            STOP:       if (tmr_tc) state_nxt = HOLD;
            HOLD:       if (!rts_s) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
        ack_nxt = state_nxt inside {WAIT_START, START, DATA, PARITY, STOP};
    end

    // Bit timer, start timeout, shift register and parity accumulator.
    // The timeout only runs in WAIT_START, so a false start does not restart it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmr  <= '0;
            tout <= '0;
            bidx <= '0;
            sh   <= '0;
            par  <= 1'b0;
        end else begin
            case (state)
                IDLE: tout <= TOUT_LOAD;
                WAIT_START: begin
                    if (!rx_s)            tmr  <= HALF_LOAD;
                    else if (tout != '0)  tout <= tout - TOUT_ONE;
                end
                START: begin
                    if (tmr_tc) begin
                        tmr  <= BIT_LOAD;
                        bidx <= '0;
                        par  <= 1'b0;
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                DATA: begin
                    if (tmr_tc) begin
                        tmr  <= BIT_LOAD;
                        sh   <= {sh[1:7], rx_s};
                        par  <= par ^ rx_s;
                        bidx <= bidx + 4'd1;
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                PARITY: begin
                    if (tmr_tc) begin
                        tmr <= BIT_LOAD;
                        par <= par ^ rx_s;
                    end else begin
                        tmr <= tmr - TMR_ONE;
                    end
                end
                STOP: if (!tmr_tc) tmr <= tmr - TMR_ONE;
                default: ;
            endcase
        end
    end

    // Host buffer: commit from the STOP sample, or consume on rd.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_r <= 1'b0;
            q_r   <= '0;
            dv_r  <= 1'b0;
            pe_r  <= 1'b0;
            fe_r  <= 1'b0;
            ovr_r <= 1'b0;
        end else begin
            ack_r <= ack_nxt;
            if (commit) begin
                q_r  <= sh;
                pe_r <= ~par;
                fe_r <= ~rx_s;
                dv_r <= 1'b1;
                if (bus.rd)     ovr_r <= 1'b0;
                else if (dv_r)  ovr_r <= 1'b1;
            end else if (bus.rd && dv_r) begin
                dv_r  <= 1'b0;
                pe_r  <= 1'b0;
                fe_r  <= 1'b0;
                ovr_r <= 1'b0;
            end
        end
    end

    assign bus.ack = ack_r;
    assign bus.q   = q_r;
    assign bus.dv  = dv_r;
    assign bus.pe  = pe_r;
    assign bus.fe  = fe_r;
    assign bus.ovr = ovr_r;
endmodule
